// File: rtl/keypulse_hex_fsm.sv
// Two-digit BCD up/down counter driven by single-cycle key pulses, shown on two
// active-low 7-segment digits; wrap-around in either direction blinks the display.
module keypulse_hex_fsm #(
  parameter int MAX_COUNT = 99,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pulse,
  input  logic       up,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic       ovf,
  output logic [6:0] HEX0_D,
  output logic [6:0] HEX1_D,
  output logic [1:0] dbg_state
);

  // Handshake: key_pulse is a plain strobe with no ready; every cycle it is
  // sampled high is one event, and up qualifies that same cycle's event.

  localparam int              BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]      MAX_BCD    = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};
  localparam logic [6:0]      SEG_DASH   = 7'b0111111;
  localparam logic [6:0]      SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_WRAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [7:0]    count_n;
  logic          ovf_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase_on, phase_on_n;

  logic [7:0]    inc_bcd, dec_bcd, step_val;
  logic          step_wrap;

  assign dbg_state = state;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count_bcd <= 8'h00;
      ovf       <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      state     <= state_n;
      count_bcd <= count_n;
      ovf       <= ovf_n;
      blink_cnt <= blink_cnt_n;
      phase_on  <= phase_on_n;
    end
  end

  // One BCD step in the requested direction, with the wrap decision alongside.
  always_comb begin
    inc_bcd = count_bcd;
    dec_bcd = count_bcd;
    if (count_bcd[3:0] == 4'd9) begin
      inc_bcd = {count_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      inc_bcd = {count_bcd[7:4], count_bcd[3:0] + 4'd1};
    end
    if (count_bcd[3:0] == 4'd0) begin
      dec_bcd = {count_bcd[7:4] - 4'd1, 4'd9};
    end else begin
      dec_bcd = {count_bcd[7:4], count_bcd[3:0] - 4'd1};
    end
    if (up) begin
      step_wrap = (count_bcd == MAX_BCD);
      step_val  = step_wrap ? 8'h00 : inc_bcd;
    end else begin
      step_wrap = (count_bcd == 8'h00);
      step_val  = step_wrap ? MAX_BCD : dec_bcd;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count_bcd;
    blink_cnt_n = blink_cnt;
    phase_on_n  = phase_on;
    if (clear) begin
      state_n     = S_IDLE;
      count_n     = 8'h00;
      blink_cnt_n = '0;
      phase_on_n  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_pulse) begin
            state_n = S_COUNT;
            count_n = 8'h00;
          end
        end
        S_COUNT, S_WRAP: begin
          if (key_pulse) begin
            count_n     = step_val;
            state_n     = step_wrap ? S_WRAP : S_COUNT;
            blink_cnt_n = '0;
            phase_on_n  = 1'b1;
          end else if (state == S_WRAP) begin
            // Blink timebase only runs while wrapped.
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt_n = '0;
              phase_on_n  = ~phase_on;
            end else begin
              blink_cnt_n = blink_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n     = S_IDLE;
          count_n     = 8'h00;
          blink_cnt_n = '0;
          phase_on_n  = 1'b1;
        end
      endcase
    end
    ovf_n = (state_n == S_WRAP);
  end

  always_comb begin
    HEX0_D = SEG_DASH;
    HEX1_D = SEG_DASH;
    case (state)
      S_COUNT: begin
        HEX0_D = seg7(count_bcd[3:0]);
        HEX1_D = seg7(count_bcd[7:4]);
      end
      S_WRAP: begin
        HEX0_D = phase_on ? seg7(count_bcd[3:0]) : SEG_BLANK;
        HEX1_D = phase_on ? seg7(count_bcd[7:4]) : SEG_BLANK;
      end
      default: begin
        HEX0_D = SEG_DASH;
        HEX1_D = SEG_DASH;
      end
    endcase
  end

endmodule
